// File: rtl/c7b_biu_pkg.sv
// rtl/c7b_biu_pkg.sv - AXI read-channel constants shared by the BIU read front-end
package c7b_biu_pkg;

  localparam int ARLEN_W  = 8;
  localparam int ARSIZE_W = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
      default:                          err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/c7b_biu_rd_mux_if.sv
// rtl/c7b_biu_rd_mux_if.sv - requestor, AR and R signal bundle of the N-port read front-end
interface c7b_biu_rd_mux_if #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int IDW   = 4
);
  import c7b_biu_pkg::*;

  logic [NPORT-1:0]          req_valid;
  logic [NPORT*AW-1:0]       req_addr;
  logic [NPORT*ARLEN_W-1:0]  req_len;
  logic [NPORT*ARSIZE_W-1:0] req_size;
  logic [NPORT-1:0]          req_cancel;
  logic [NPORT-1:0]          req_ack;
  logic [NPORT-1:0]          rsp_valid;
  logic [DW-1:0]             rsp_data;
  logic                      rsp_last;
  logic                      rsp_err;
  logic                      err_unexp;

  logic                      ar_valid;
  logic                      ar_ready;
  logic [IDW-1:0]            ar_id;
  logic [AW-1:0]             ar_addr;
  logic [ARLEN_W-1:0]        ar_len;
  logic [ARSIZE_W-1:0]       ar_size;
  logic [1:0]                ar_burst;

  logic                      r_valid;
  logic                      r_ready;
  logic [IDW-1:0]            r_id;
  logic [DW-1:0]             r_data;
  logic [1:0]                r_resp;
  logic                      r_last;

  // slave: the read front-end itself; master: requestors plus AXI slave side
  modport slave (
    input  req_valid, req_addr, req_len, req_size, req_cancel,
    output req_ack, rsp_valid, rsp_data, rsp_last, rsp_err, err_unexp,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport master (
    output req_valid, req_addr, req_len, req_size, req_cancel,
    input  req_ack, rsp_valid, rsp_data, rsp_last, rsp_err, err_unexp,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/c7b_rr_arb.sv
// rtl/c7b_rr_arb.sv - round-robin arbiter, one-hot grant, priority rotates past each winner
module c7b_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_any;

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!w_any && i_req[j]) begin
        o_gnt[j] = 1'b1;
        w_win    = PW'(j);
        w_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end
  end

endmodule

// File: rtl/c7b_biu_rd_mux.sv
// rtl/c7b_biu_rd_mux.sv - N-port AXI read front-end: RR onto one AR slot, R routing by ARID, cancel with drain
module c7b_biu_rd_mux #(
  parameter int NPORT  = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int IDW    = 4,
  parameter int MAXOUT = 4
) (
  input logic             clk,
  input logic             reset,
  c7b_biu_rd_mux_if.slave bus
);
  import c7b_biu_pkg::*;

  localparam int CW = $clog2(MAXOUT) + 1;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [CW-1:0]       r_outst [NPORT];
  logic [CW-1:0]       r_drain [NPORT];
  logic                r_ar_valid;
  logic [IDW-1:0]      r_ar_id;
  logic [AW-1:0]       r_ar_addr;
  logic [ARLEN_W-1:0]  r_ar_len;
  logic [ARSIZE_W-1:0] r_ar_size;
  logic [NPORT-1:0]    r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic                r_rsp_last;
  logic                r_rsp_err;
  logic                r_err_unexp;

  logic                w_slot_free;
  logic [NPORT-1:0]    w_elig;
  logic [NPORT-1:0]    w_gnt;
  logic [NPORT-1:0]    w_ack;
  logic [NPORT-1:0]    w_hit;
  logic [NPORT-1:0]    w_deliver;
  logic [CW-1:0]       w_outst_nxt [NPORT];
  logic [PW-1:0]       w_win_idx;
  logic [AW-1:0]       w_win_addr;
  logic [ARLEN_W-1:0]  w_win_len;
  logic [ARSIZE_W-1:0] w_win_size;

  c7b_rr_arb #(.N(NPORT)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .i_req     (w_elig),
    .i_advance (w_slot_free),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_slot_free = ~r_ar_valid | bus.ar_ready;
    w_ack       = (w_slot_free && !reset) ? w_gnt : '0;
    w_win_idx   = '0;
    w_win_addr  = '0;
    w_win_len   = '0;
    w_win_size  = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_elig[p] = bus.req_valid[p] & ~bus.req_cancel[p] &
                  (r_outst[p] < CW'(MAXOUT)) & (r_drain[p] == '0);
      // Out-of-range IDs match no port and therefore count as unexpected
      w_hit[p]     = bus.r_valid & (bus.r_id == IDW'(p)) & (r_outst[p] != '0);
      w_deliver[p] = w_hit[p] & (r_drain[p] == '0) & ~bus.req_cancel[p];
      w_outst_nxt[p] = r_outst[p] + CW'(w_ack[p]) - CW'(w_hit[p] & bus.r_last);
      if (w_gnt[p]) begin
        w_win_idx  = PW'(p);
        w_win_addr = bus.req_addr[p*AW +: AW];
        w_win_len  = bus.req_len[p*ARLEN_W +: ARLEN_W];
        w_win_size = bus.req_size[p*ARSIZE_W +: ARSIZE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ar_valid <= 1'b0;
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
    end else if (w_slot_free) begin
      r_ar_valid <= |w_ack;
      if (|w_ack) begin
        r_ar_id   <= IDW'(w_win_idx);
        r_ar_addr <= w_win_addr;
        r_ar_len  <= w_win_len;
        r_ar_size <= w_win_size;
      end
    end
  end

  // A cancel snapshots the post-update count, so the burst still parked in the AR slot is drained too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NPORT; p++) begin
        r_outst[p] <= '0;
        r_drain[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        r_outst[p] <= w_outst_nxt[p];
        if (bus.req_cancel[p]) begin
          r_drain[p] <= w_outst_nxt[p];
        end else if (w_hit[p] && bus.r_last && r_drain[p] != '0) begin
          r_drain[p] <= r_drain[p] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      r_rsp_valid <= w_deliver;
      r_rsp_last  <= (|w_deliver) & bus.r_last;
      r_rsp_err   <= (|w_deliver) & resp_is_err(bus.r_resp);
      if (|w_deliver) r_rsp_data <= bus.r_data;
      if (bus.r_valid && !(|w_hit)) r_err_unexp <= 1'b1;
    end
  end

  assign bus.req_ack   = w_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.err_unexp = r_err_unexp;
  assign bus.ar_valid  = r_ar_valid;
  assign bus.ar_id     = r_ar_id;
  assign bus.ar_addr   = r_ar_addr;
  assign bus.ar_len    = r_ar_len;
  assign bus.ar_size   = r_ar_size;
  assign bus.ar_burst  = AXI_BURST_INCR;
  assign bus.r_ready   = 1'b1;

endmodule

// File: tb/tb_c7b_biu_rd_mux.sv
// tb/tb_c7b_biu_rd_mux.sv - directed scenarios plus random traffic against a cycle reference model
module tb_c7b_biu_rd_mux;

  localparam int N      = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int IDW    = 4;
  localparam int MAXOUT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  c7b_biu_rd_mux_if #(.NPORT(N), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

  c7b_biu_rd_mux #(.NPORT(N), .AW(AW), .DW(DW), .IDW(IDW), .MAXOUT(MAXOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: counts per port, the pending AR, the expected response register
  int             m_outst [N];
  int             m_drain [N];
  int             m_last;
  bit             m_arv;
  logic [IDW-1:0] m_arid;
  logic [AW-1:0]  m_araddr;
  logic [7:0]     m_arlen;
  logic [2:0]     m_arsize;
  logic [N-1:0]   m_rspv;
  logic [DW-1:0]  m_rspd;
  bit             m_rspl, m_rspe, m_err;
  int             sq [N][$];

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_outst[p] = 0;
      m_drain[p] = 0;
      sq[p].delete();
    end
    m_last = N - 1;
    m_arv = 0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_rspv = '0; m_rspd = '0; m_rspl = 0; m_rspe = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rv, cn;
    bit free, hit, deliver, dec;
    int win, id, nx;
    rv = bus.req_valid;
    cn = bus.req_cancel;
    free = !m_arv || bus.ar_ready;
    win = -1;
    if (free) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (win < 0 && rv[p] && !cn[p] && m_outst[p] < MAXOUT && m_drain[p] == 0) win = p;
      end
    end
    chk("req_ack", bus.req_ack, (win >= 0) ? (64'd1 << win) : 64'd0);
    chk("ar_valid", bus.ar_valid, m_arv);
    if (m_arv) begin
      chk("ar_addr", bus.ar_addr, m_araddr);
      chk("ar_payload", {bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst},
          {m_arid, m_arlen, m_arsize, 2'b01});
    end
    chk("rsp_valid", bus.rsp_valid, m_rspv);
    if (m_rspv != 0) chk("rsp_beat", {bus.rsp_data, bus.rsp_last, bus.rsp_err}, {m_rspd, m_rspl, m_rspe});
    chk("err_unexp", bus.err_unexp, m_err);
    chk("r_ready", bus.r_ready, 1'b1);
    if (m_arv && bus.ar_ready) sq[m_arid].push_back(int'(m_arlen) + 1);
    if (free) begin
      m_arv = (win >= 0);
      if (win >= 0) begin
        m_last   = win;
        m_arid   = IDW'(win);
        m_araddr = bus.req_addr[win*AW +: AW];
        m_arlen  = bus.req_len[win*8 +: 8];
        m_arsize = bus.req_size[win*3 +: 3];
      end
    end
    id = int'(bus.r_id);
    hit = 0;
    if (bus.r_valid && id < N) hit = (m_outst[id] > 0);
    if (bus.r_valid && !hit) m_err = 1;
    deliver = 0;
    if (hit) deliver = (m_drain[id] == 0) && !cn[id];
    m_rspv = '0;
    if (deliver) begin
      m_rspv[id] = 1'b1;
      m_rspd = bus.r_data;
    end
    m_rspl = deliver && bus.r_last;
    m_rspe = deliver && bus.r_resp[1];
    for (int p = 0; p < N; p++) begin
      dec = hit && id == p && bus.r_last;
      nx = m_outst[p] + ((win == p) ? 1 : 0) - (dec ? 1 : 0);
      m_outst[p] = nx;
      if (cn[p]) m_drain[p] = nx;
      else if (dec && m_drain[p] > 0) m_drain[p] = m_drain[p] - 1;
    end
  endtask

  always @(negedge clk) if (!reset) model_step();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0; bus.req_cancel = '0; bus.ar_ready = 1'b1;
    bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
    bus.req_valid[p] = 1'b1;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_len[p*8 +: 8] = l;
    bus.req_size[p*3 +: 3] = s;
  endtask

  task automatic beat(input int id, input bit last, input logic [1:0] resp, input logic [DW-1:0] d);
    bus.r_valid = 1'b1; bus.r_id = IDW'(id); bus.r_last = last; bus.r_resp = resp; bus.r_data = d;
  endtask

  task automatic slave_beat();
    int c[$];
    int p;
    bus.r_valid = 1'b0;
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) c.push_back(i);
    if (c.size() == 0) return;
    p = c[$urandom_range(0, c.size() - 1)];
    beat(p, sq[p][0] == 1, 2'($urandom_range(0, 3)), $urandom);
    if (sq[p][0] == 1) sq[p].pop_front();
    else sq[p][0] = sq[p][0] - 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int seq2 [6] = '{1, 1, 0, 1, 0, 0};

  initial begin
    logic [N-1:0] acks [6];
    int cnt, lastcnt;
    bit done;
    idle();
    model_reset();
    cyc();
    chk("reset_outputs", {bus.ar_valid, bus.req_ack, bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.err_unexp}, 0);
    chk("reset_data", bus.rsp_data, 0);
    reset = 1'b0;

    // single read, 4 beats
    set_req(0, 32'h1000, 8'd3, 3'd2);
    @(negedge clk);
    chk("t1_ack", bus.req_ack, 2'b01);
    cyc();
    bus.req_valid = '0;
    chk("t1_ar", {bus.ar_valid, bus.ar_id, bus.ar_addr}, {1'b1, 4'd0, 32'h1000});
    cnt = 0; lastcnt = 0;
    for (int b = 0; b < 5; b++) begin
      if (b < 4) beat(0, b == 3, 2'b00, 32'hD0 + b);
      else bus.r_valid = 1'b0;
      cyc();
      cnt += int'(bus.rsp_valid[0]);
      lastcnt += int'(bus.rsp_last);
    end
    chk("t1_beats", cnt, 4);
    chk("t1_last", lastcnt, 1);

    // contention alternates, out-of-order R routes by id
    do_reset();
    set_req(0, 32'h2000, 8'd0, 3'd2);
    set_req(1, 32'h3000, 8'd0, 3'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acks[i] = bus.req_ack;
    end
    cyc();
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) chk($sformatf("t2_gnt%0d", i), acks[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int k = 0; k < 6; k++) begin
      beat(seq2[k], 1'b1, 2'b00, 32'hB000 + k);
      cyc();
      chk($sformatf("t2_route%0d", k), bus.rsp_valid, 2'b01 << seq2[k]);
    end
    bus.r_valid = 1'b0;

    // outstanding limit
    do_reset();
    set_req(1, 32'h4000, 8'd0, 3'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acks[i] = bus.req_ack;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("t3_ack%0d", i), acks[i], (i < 4) ? 2'b10 : 2'b00);
    cyc();
    beat(1, 1'b1, 2'b00, 32'h44);
    @(negedge clk);
    chk("t3_ack_beat_cycle", bus.req_ack, 2'b00);
    cyc();
    bus.r_valid = 1'b0;
    @(negedge clk);
    chk("t3_reack", bus.req_ack, 2'b10);

    // cancel with two issued and one parked in the AR slot
    do_reset();
    set_req(0, 32'h5000, 8'd0, 3'd2);
    cyc(); cyc(); cyc();
    bus.req_valid = '0; bus.ar_ready = 1'b0; bus.req_cancel = 2'b01;
    cyc();
    bus.req_cancel = '0; bus.req_valid[0] = 1'b1; bus.ar_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat(0, 1'b1, 2'b00, 32'hC0 + k);
      @(negedge clk);
      chk($sformatf("t4_hold%0d", k), bus.req_ack, 2'b00);
      cyc();
      chk($sformatf("t4_silent%0d", k), bus.rsp_valid, 2'b00);
    end
    bus.r_valid = 1'b0;
    @(negedge clk);
    chk("t4_reack", bus.req_ack, 2'b01);

    // random traffic
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      cyc();
      for (int p = 0; p < N; p++) begin
        bus.req_valid[p] = ($urandom_range(0, 2) != 0);
        bus.req_addr[p*AW +: AW] = $urandom;
        bus.req_len[p*8 +: 8] = 8'($urandom_range(0, 3));
        bus.req_size[p*3 +: 3] = 3'($urandom_range(0, 2));
        bus.req_cancel[p] = ($urandom_range(0, 39) == 0);
      end
      bus.ar_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) slave_beat();
      else bus.r_valid = 1'b0;
    end
    cyc();
    bus.req_valid = '0; bus.req_cancel = '0; bus.ar_ready = 1'b1;
    done = 0;
    for (int t = 0; t < 1000 && !done; t++) begin
      cyc();
      done = !m_arv;
      for (int p = 0; p < N; p++) if (m_outst[p] != 0 || sq[p].size() != 0) done = 0;
      if (!done) slave_beat();
      else bus.r_valid = 1'b0;
    end
    chk("rand_drained", done, 1'b1);

    // stray beat and error response
    do_reset();
    beat(5, 1'b1, 2'b00, 32'h55);
    cyc();
    bus.r_valid = 1'b0;
    chk("t5_unexp", bus.err_unexp, 1'b1);
    chk("t5_drop", bus.rsp_valid, 2'b00);
    set_req(0, 32'h6000, 8'd1, 3'd2);
    @(negedge clk);
    chk("t5_ack", bus.req_ack, 2'b01);
    cyc();
    bus.req_valid = '0;
    beat(0, 1'b0, 2'b10, 32'h61);
    cyc();
    chk("t5_err_beat", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b01, 1'b1, 32'h61});
    beat(0, 1'b1, 2'b00, 32'h62);
    cyc();
    chk("t5_ok_beat", {bus.rsp_valid, bus.rsp_err, bus.rsp_last}, {2'b01, 1'b0, 1'b1});
    bus.r_valid = 1'b0;
    chk("t5_sticky", bus.err_unexp, 1'b1);

    // reset mid-burst
    cyc();
    set_req(0, 32'h7000, 8'd0, 3'd2);
    cyc(); cyc();
    bus.ar_ready = 1'b0;
    beat(0, 1'b0, 2'b00, 32'h77);
    cyc();
    bus.r_valid = 1'b0;
    chk("t6_pre", {bus.ar_valid, bus.rsp_valid}, {1'b1, 2'b01});
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_rst", {bus.ar_valid, bus.req_ack, bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.err_unexp}, 0);
    chk("t6_rst_data", bus.rsp_data, 0);
    idle();
    cyc(); cyc();
    reset = 1'b0;
    beat(0, 1'b1, 2'b00, 32'h78);
    cyc();
    bus.r_valid = 1'b0;
    chk("t6_stray", bus.err_unexp, 1'b1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
